// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: pipeline sequencing controller for the i2d core.
// Decides stalls (load-use, memory access wait), redirects (branch, rfe,
// exceptions) and the flush sequence that follows every redirect. It also
// holds the exception state (epc, exc_cause, in_exc).
//
// Handshake note: there is no valid/ready pair here. mau_busy is a level
// "not ready" from the memory access unit. While it is high, fetch and decode
// are held, and no redirect is taken.
module core_pipe_ctrl #(
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter int          REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_pc,
    input  logic              id_branch,
    input  logic              id_swi,
    input  logic              id_rfe,
    input  logic              id_err,
    input  logic              id_imm,
    input  logic [REG_AW-1:0] rega_addr,
    input  logic [REG_AW-1:0] regb_addr,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_wb_addr,
    input  logic              mau_busy,
    input  logic              irq,
    output logic              if_halt,
    output logic              id_halt,
    output logic              id_flush,
    output logic              ex_flush,
    output logic [1:0]        pc_sel,
    output logic [31:0]       vec_addr,
    output logic [31:0]       epc,
    output logic [1:0]        exc_cause,
    output logic              in_exc
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LD_STALL = 2'd1;
    localparam logic [1:0] ST_MAU_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_VEC    = 2'd2;
    localparam logic [1:0] PC_EPC    = 2'd3;

    localparam logic [1:0] CAUSE_IRQ = 2'd0;
    localparam logic [1:0] CAUSE_SWI = 2'd1;
    localparam logic [1:0] CAUSE_ILL = 2'd2;

    // The decision cycle itself is the first flush cycle, so FLUSH holds the
    // rest. With a single flush cycle the FLUSH state is skipped entirely.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [1:0] REDIRECT_ST = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    logic [1:0]  state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic        in_exc_q, in_exc_d;

    logic        exc_take;
    logic [1:0]  exc_code;
    logic        load_use;

    // Decode-side hazard and exception qualifiers; irq is masked inside a handler.
    always_comb begin
        exc_take = id_err | id_swi | (irq & ~in_exc_q);
        if (id_err) begin
            exc_code = CAUSE_ILL;
        end else if (id_swi) begin
            exc_code = CAUSE_SWI;
        end else begin
            exc_code = CAUSE_IRQ;
        end
        load_use = ex_load & ((ex_wb_addr == rega_addr) |
                              (~id_imm & (ex_wb_addr == regb_addr)));
    end

    // Next-state, exception-state update and combinational control outputs.
    // Everything is forced quiet while rst is low so that mau_busy cannot
    // leak into the halts during reset.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        epc_d       = epc_q;
        exc_cause_d = exc_cause_q;
        in_exc_d    = in_exc_q;
        if_halt     = 1'b0;
        id_halt     = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        pc_sel      = PC_SEQ;
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (mau_busy) begin
                        if_halt = 1'b1;
                        id_halt = 1'b1;
                        state_d = ST_MAU_WAIT;
                    end else if (exc_take) begin
                        pc_sel      = PC_VEC;
                        id_flush    = 1'b1;
                        ex_flush    = 1'b1;
                        epc_d       = id_pc;
                        exc_cause_d = exc_code;
                        in_exc_d    = 1'b1;
                        flush_cnt_d = FLUSH_INIT;
                        state_d     = REDIRECT_ST;
                    end else if (id_rfe) begin
                        pc_sel      = PC_EPC;
                        id_flush    = 1'b1;
                        in_exc_d    = 1'b0;
                        flush_cnt_d = FLUSH_INIT;
                        state_d     = REDIRECT_ST;
                    end else if (id_branch) begin
                        pc_sel      = PC_BRANCH;
                        id_flush    = 1'b1;
                        flush_cnt_d = FLUSH_INIT;
                        state_d     = REDIRECT_ST;
                    end else if (load_use) begin
                        if_halt  = 1'b1;
                        id_halt  = 1'b1;
                        ex_flush = 1'b1;
                        state_d  = ST_LD_STALL;
                    end
                end
                ST_LD_STALL: begin
                    // EX already holds the bubble; no re-check of the hazard.
                    state_d = ST_RUN;
                end
                ST_MAU_WAIT: begin
                    if (mau_busy) begin
                        if_halt = 1'b1;
                        id_halt = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // ST_FLUSH: decode indications and irq are ignored here.
                    id_flush = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    // State and exception registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            epc_q       <= 32'd0;
            exc_cause_q <= CAUSE_IRQ;
            in_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            epc_q       <= epc_d;
            exc_cause_q <= exc_cause_d;
            in_exc_q    <= in_exc_d;
        end
    end

    // Registered exception state and the vector derived from the cause.
    always_comb begin
        epc       = epc_q;
        exc_cause = exc_cause_q;
        in_exc    = in_exc_q;
        vec_addr  = VEC_BASE + {26'd0, exc_cause_q, 4'd0};
    end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Testbench for core_pipe_ctrl (FLUSH_CYCLES = 2, VEC_BASE = 0x100).
// A table of per-cycle records is driven. Each record's expected outputs are
// pushed to a scoreboard queue. The queue is popped and compared mid-cycle.
// A randomized load-use sweep follows the table.
module tb_core_pipe_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] VEC_BASE     = 32'h0000_0100;
  localparam int          REG_AW       = 5;
  localparam int          EXP_W        = 4 + 2 + 1 + 2 + 32;

  // Input flag bits for the table
  localparam logic [6:0] F_B = 7'h40;  // id_branch
  localparam logic [6:0] F_S = 7'h20;  // id_swi
  localparam logic [6:0] F_R = 7'h10;  // id_rfe
  localparam logic [6:0] F_E = 7'h08;  // id_err
  localparam logic [6:0] F_I = 7'h04;  // irq
  localparam logic [6:0] F_M = 7'h02;  // mau_busy
  localparam logic [6:0] F_L = 7'h01;  // ex_load

  typedef struct {
    string       name;
    logic        rst_n;
    logic [31:0] pc;
    logic [6:0]  flags;
    logic        imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wb;
    logic [3:0]  ctl;    // {if_halt, id_halt, id_flush, ex_flush}
    logic [1:0]  sel;
    logic        inx;
    logic [1:0]  cause;
    logic [31:0] epc;
  } vec_t;

  logic              clk;
  logic              rst;
  logic [31:0]       id_pc;
  logic              id_branch, id_swi, id_rfe, id_err, id_imm;
  logic [REG_AW-1:0] rega_addr, regb_addr, ex_wb_addr;
  logic              ex_load, mau_busy, irq;
  logic              if_halt, id_halt, id_flush, ex_flush;
  logic [1:0]        pc_sel;
  logic [31:0]       vec_addr;
  logic [31:0]       epc;
  logic [1:0]        exc_cause;
  logic              in_exc;

  logic [EXP_W-1:0]  exp_q[$];
  vec_t              vecs[$];
  int                n_checks;
  int                n_fail;

  core_pipe_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .VEC_BASE(VEC_BASE),
    .REG_AW(REG_AW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_branch(id_branch), .id_swi(id_swi), .id_rfe(id_rfe),
    .id_err(id_err), .id_imm(id_imm),
    .rega_addr(rega_addr), .regb_addr(regb_addr),
    .ex_load(ex_load), .ex_wb_addr(ex_wb_addr),
    .mau_busy(mau_busy), .irq(irq),
    .if_halt(if_halt), .id_halt(id_halt), .id_flush(id_flush), .ex_flush(ex_flush),
    .pc_sel(pc_sel), .vec_addr(vec_addr), .epc(epc),
    .exc_cause(exc_cause), .in_exc(in_exc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- table helper ----------------
  function automatic vec_t mk(input string nm, input logic r, input logic [31:0] pc,
                              input logic [6:0] fl, input logic imm,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wb,
                              input logic [3:0] ctl, input logic [1:0] sel, input logic inx,
                              input logic [1:0] cause, input logic [31:0] e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.pc = pc; v.flags = fl; v.imm = imm;
    v.ra = ra; v.rb = rb; v.wb = wb;
    v.ctl = ctl; v.sel = sel; v.inx = inx; v.cause = cause; v.epc = e;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs just after the rising edge and pushes the
  // outputs expected for that cycle onto the scoreboard.
  task automatic drive(input logic r, input logic [31:0] pc, input logic [6:0] fl,
                       input logic imm, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] wb, input logic [EXP_W-1:0] expv);
    @(posedge clk);
    #1;
    rst        = r;
    id_pc      = pc;
    id_branch  = fl[6];
    id_swi     = fl[5];
    id_rfe     = fl[4];
    id_err     = fl[3];
    irq        = fl[2];
    mau_busy   = fl[1];
    ex_load    = fl[0];
    id_imm     = imm;
    rega_addr  = ra;
    regb_addr  = rb;
    ex_wb_addr = wb;
    exp_q.push_back(expv);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_field(input string nm, input string fld,
                             input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
    end
  endtask

  task automatic sample(input string nm);
    logic [EXP_W-1:0] e;
    logic [1:0]       e_cause;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.queue: got empty scoreboard, expected an entry", nm);
    end else begin
      e       = exp_q.pop_front();
      e_cause = e[33:32];
      check_field(nm, "ctl", {28'd0, if_halt, id_halt, id_flush, ex_flush}, {28'd0, e[40:37]});
      check_field(nm, "pc_sel", {30'd0, pc_sel}, {30'd0, e[36:35]});
      check_field(nm, "in_exc", {31'd0, in_exc}, {31'd0, e[34]});
      check_field(nm, "exc_cause", {30'd0, exc_cause}, {30'd0, e_cause});
      check_field(nm, "epc", epc, e[31:0]);
      check_field(nm, "vec_addr", vec_addr, VEC_BASE + 32'(e_cause) * 32'd16);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  r_wb, r_ra, r_rb;
    logic        r_ld, r_imm, hazard;
    logic [6:0]  r_fl;
    string       nm;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; id_pc = '0; id_branch = 0; id_swi = 0; id_rfe = 0; id_err = 0;
    id_imm = 0; rega_addr = 5'd1; regb_addr = 5'd2; ex_load = 0; ex_wb_addr = '0;
    mau_busy = 0; irq = 0;

    //               name       rst pc     flags          imm ra rb wb  ctl      sel inx cause epc
    // reset during mau_busy, then the first RUN cycle honours mau_busy
    vecs.push_back(mk("rst0",   0, 0,     F_M,           0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("rst1",   0, 0,     F_M,           0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("rst2",   0, 0,     F_M,           0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("rel_mau",1, 0,     F_M,           0, 1, 2, 0, 4'b1100, 0, 0, 0, 0));
    vecs.push_back(mk("mau_rel",1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("idle0",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    // branch with two flush cycles
    vecs.push_back(mk("br_T",   1, 0,     F_B,           0, 1, 2, 0, 4'b0010, 1, 0, 0, 0));
    vecs.push_back(mk("br_T1",  1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 0, 0, 0));
    vecs.push_back(mk("br_T2",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    // load-use on rega, hazard not re-checked in LD_STALL
    vecs.push_back(mk("lu_a",   1, 0,     F_L,           0, 3, 2, 3, 4'b1101, 0, 0, 0, 0));
    vecs.push_back(mk("lu_a1",  1, 0,     F_L,           0, 3, 2, 3, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("idle1",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("lu_bimm",1, 0,     F_L,           1, 1, 3, 3, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("lu_b",   1, 0,     F_L,           0, 1, 3, 3, 4'b1101, 0, 0, 0, 0));
    vecs.push_back(mk("lu_b1",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    // priority: illegal beats swi beats irq
    vecs.push_back(mk("pri",    1, 32'h40, F_E|F_S|F_I,  0, 1, 2, 0, 4'b0011, 2, 0, 0, 0));
    vecs.push_back(mk("pri_f",  1, 0,     F_I,           0, 1, 2, 0, 4'b0010, 0, 1, 2, 32'h40));
    vecs.push_back(mk("irq_m0", 1, 0,     F_I,           0, 1, 2, 0, 4'b0000, 0, 1, 2, 32'h40));
    vecs.push_back(mk("irq_m1", 1, 0,     F_I,           0, 1, 2, 0, 4'b0000, 0, 1, 2, 32'h40));
    // nested swi still taken while in_exc
    vecs.push_back(mk("nest",   1, 32'h80, F_S|F_I,      0, 1, 2, 0, 4'b0011, 2, 1, 2, 32'h40));
    vecs.push_back(mk("nest_f", 1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 1, 1, 32'h80));
    vecs.push_back(mk("rfe",    1, 0,     F_R,           0, 1, 2, 0, 4'b0010, 3, 1, 1, 32'h80));
    vecs.push_back(mk("rfe_f",  1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 0, 1, 32'h80));
    // irq accepted after rfe
    vecs.push_back(mk("irq",    1, 32'h90, F_I,          0, 1, 2, 0, 4'b0011, 2, 0, 1, 32'h80));
    vecs.push_back(mk("irq_f",  1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 1, 0, 32'h90));
    vecs.push_back(mk("rfe2",   1, 0,     F_R,           0, 1, 2, 0, 4'b0010, 3, 1, 0, 32'h90));
    vecs.push_back(mk("rfe2_f", 1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 0, 0, 32'h90));
    vecs.push_back(mk("idle2",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 32'h90));
    // mau_busy dominates a branch for 4 cycles; redirect after release
    vecs.push_back(mk("mb0",    1, 0,     F_M|F_B,       0, 1, 2, 0, 4'b1100, 0, 0, 0, 32'h90));
    vecs.push_back(mk("mb1",    1, 0,     F_M|F_B,       0, 1, 2, 0, 4'b1100, 0, 0, 0, 32'h90));
    vecs.push_back(mk("mb2",    1, 0,     F_M|F_B,       0, 1, 2, 0, 4'b1100, 0, 0, 0, 32'h90));
    vecs.push_back(mk("mb3",    1, 0,     F_M|F_B,       0, 1, 2, 0, 4'b1100, 0, 0, 0, 32'h90));
    vecs.push_back(mk("mb_rel", 1, 0,     F_B,           0, 1, 2, 0, 4'b0000, 0, 0, 0, 32'h90));
    vecs.push_back(mk("mb_br",  1, 0,     F_B,           0, 1, 2, 0, 4'b0010, 1, 0, 0, 32'h90));
    vecs.push_back(mk("mb_f",   1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 0, 0, 32'h90));
    vecs.push_back(mk("idle3",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 32'h90));
    // reset mid-FLUSH clears everything
    vecs.push_back(mk("rf_br",  1, 0,     F_B,           0, 1, 2, 0, 4'b0010, 1, 0, 0, 32'h90));
    vecs.push_back(mk("rf_rst", 0, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("rf_run", 1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    // reset mid-MAU_WAIT returns to RUN (hazard detected right away)
    vecs.push_back(mk("rm_mau", 1, 0,     F_M,           0, 1, 2, 0, 4'b1100, 0, 0, 0, 0));
    vecs.push_back(mk("rm_rst", 0, 0,     F_M,           0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("rm_run", 1, 0,     F_L,           0, 7, 2, 7, 4'b1101, 0, 0, 0, 0));
    vecs.push_back(mk("rm_ld",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    // swi held behind mau_busy, taken after release
    vecs.push_back(mk("ms0",    1, 32'hA0, F_M|F_S,      0, 1, 2, 0, 4'b1100, 0, 0, 0, 0));
    vecs.push_back(mk("ms_rel", 1, 32'hA0, F_S,          0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("ms_swi", 1, 32'hA0, F_S,          0, 1, 2, 0, 4'b0011, 2, 0, 0, 0));
    vecs.push_back(mk("ms_f",   1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 1, 1, 32'hA0));
    vecs.push_back(mk("ms_rfe", 1, 0,     F_R,           0, 1, 2, 0, 4'b0010, 3, 1, 1, 32'hA0));
    vecs.push_back(mk("ms_rf",  1, 0,     0,             0, 1, 2, 0, 4'b0010, 0, 0, 1, 32'hA0));
    vecs.push_back(mk("idle4",  1, 0,     0,             0, 1, 2, 0, 4'b0000, 0, 0, 1, 32'hA0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].pc, vecs[i].flags, vecs[i].imm, vecs[i].ra, vecs[i].rb,
            vecs[i].wb, {vecs[i].ctl, vecs[i].sel, vecs[i].inx, vecs[i].cause, vecs[i].epc});
      sample(vecs[i].name);
    end

    // Randomized load-use sweep; every stall must last exactly one cycle.
    for (int k = 0; k < 40; k++) begin
      r_ld   = 1'($urandom_range(0, 1));
      r_imm  = 1'($urandom_range(0, 1));
      r_wb   = 5'($urandom_range(0, 3));
      r_ra   = 5'($urandom_range(0, 3));
      r_rb   = 5'($urandom_range(0, 3));
      hazard = r_ld && ((r_wb == r_ra) || (!r_imm && (r_wb == r_rb)));
      r_fl   = r_ld ? F_L : 7'h00;
      nm     = $sformatf("rnd%0d", k);
      drive(1'b1, 32'h0, r_fl, r_imm, r_ra, r_rb, r_wb,
            {(hazard ? 4'b1101 : 4'b0000), 2'd0, 1'b0, 2'd1, 32'hA0});
      sample(nm);
      if (hazard) begin
        drive(1'b1, 32'h0, r_fl, r_imm, r_ra, r_rb, r_wb, {4'b0000, 2'd0, 1'b0, 2'd1, 32'hA0});
        sample({nm, "_st"});
      end
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
